// File: rtl/cache_ram_bridge.sv
// cache_ram_bridge
//   RAM-side stage behind the cache controller FSM. It takes one line request,
//   which is either a refill read or a dirty write-back, and runs it as LINE_WORDS
//   single-word beats on a ready-handshaked memory port. When the line is done it
//   returns a one-cycle response pulse together with the refilled line.
//
// Optional feature: define CACHE_RAM_TIMEOUT_EN to add a per-beat stall timeout and
//   the bus_err output. With the macro undefined, XFER waits for mem_ready indefinitely.
//
// Ports
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active-low
//   enable_cache_to_ram    line request from the controller
//   write_cache_to_ram     1 = write-back, 0 = refill read
//   addr_cache_to_ram      line byte address; the offset bits are ignored
//   line_cache_to_ram      write-back line; word i is at [i*WORD_W +: WORD_W]
//   response_ram_to_cache  one-cycle transfer-done pulse
//   line_ram_to_cache      refilled line, in the same word order
//   mem_req / mem_we       beat request / beat is a write
//   mem_addr / mem_wdata   beat byte address / beat write data
//   mem_rdata / mem_ready  beat read data / beat accept-complete
//   bus_err                timeout pulse, only present with CACHE_RAM_TIMEOUT_EN
module cache_ram_bridge #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable_cache_to_ram,
   input  logic                         write_cache_to_ram,
   input  logic [ADDR_W-1:0]            addr_cache_to_ram,
   input  logic [LINE_WORDS*WORD_W-1:0] line_cache_to_ram,
   output logic                         response_ram_to_cache,
   output logic [LINE_WORDS*WORD_W-1:0] line_ram_to_cache,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [WORD_W-1:0]            mem_wdata,
   input  logic [WORD_W-1:0]            mem_rdata,
`ifdef CACHE_RAM_TIMEOUT_EN
   input  logic                         mem_ready,
   output logic                         bus_err
`else
   input  logic                         mem_ready
`endif
);

   localparam int unsigned BeatW = $clog2(LINE_WORDS);
   localparam int unsigned LineW = LINE_WORDS * WORD_W;
   localparam logic [BeatW-1:0]  LastBeat = BeatW'(LINE_WORDS - 1);
   // These are the byte-offset bits within a line. They are cleared when the base is latched.
   localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

   state_e              state_q, state_d;
   logic [BeatW-1:0]    beat_q, beat_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                we_q, we_d;
   logic [LineW-1:0]    wline_q, wline_d;
   logic [LineW-1:0]    rline_q, rline_d;

`ifdef CACHE_RAM_TIMEOUT_EN
   localparam int unsigned StallW = $clog2(TIMEOUT + 1);
   logic [StallW-1:0]   stall_q, stall_d;
   logic                err_q, err_d;
`else
   logic                unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      base_d  = base_q;
      we_d    = we_q;
      wline_d = wline_q;
      rline_d = rline_q;
`ifdef CACHE_RAM_TIMEOUT_EN
      stall_d = stall_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (enable_cache_to_ram) begin
               // The whole request is latched here, so later input changes cannot disturb the transfer.
               state_d = StXfer;
               beat_d  = '0;
               base_d  = addr_cache_to_ram & ~OffMask;
               we_d    = write_cache_to_ram;
               wline_d = line_cache_to_ram;
`ifdef CACHE_RAM_TIMEOUT_EN
               stall_d = '0;
               err_d   = 1'b0;
`endif
            end
         end
         StXfer: begin
            if (mem_ready) begin
               if (!we_q) begin
                  rline_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
               end
               if (beat_q == LastBeat) begin
                  state_d = StResp;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
`ifdef CACHE_RAM_TIMEOUT_EN
               stall_d = '0;
            end else if (stall_q == StallW'(TIMEOUT - 1)) begin
               // This is the last stall cycle allowed. The remaining beats are abandoned.
               state_d = StResp;
               err_d   = 1'b1;
            end else begin
               stall_d = stall_q + 1'b1;
`endif
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         wline_q <= '0;
         rline_q <= '0;
`ifdef CACHE_RAM_TIMEOUT_EN
         stall_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         we_q    <= we_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
`ifdef CACHE_RAM_TIMEOUT_EN
         stall_q <= stall_d;
         err_q   <= err_d;
`endif
      end
   end

   // Outputs depend only on registered state, so they hold stable while a beat stalls.
   always_comb begin
      mem_req               = 1'b0;
      mem_we                = 1'b0;
      mem_addr              = '0;
      mem_wdata             = '0;
      response_ram_to_cache = 1'b0;
      if (state_q == StXfer) begin
         mem_req   = 1'b1;
         mem_we    = we_q;
         mem_addr  = base_q + ADDR_W'({beat_q, 2'b00});
         mem_wdata = wline_q[beat_q*WORD_W +: WORD_W];
      end
      if (state_q == StResp) begin
         response_ram_to_cache = 1'b1;
      end
   end

   assign line_ram_to_cache = rline_q;

`ifdef CACHE_RAM_TIMEOUT_EN
   assign bus_err = (state_q == StResp) && err_q;
`endif

endmodule

// File: tb/tb_cache_ram_bridge.sv
// Directed self-checking bench for cache_ram_bridge (4-word lines, 32-bit words).
// Memory read data is a fixed function of the beat address, mem_addr ^ 0xA5A5_0000,
// so every expected refilled line below is a constant worked out by hand.
module tb_cache_ram_bridge;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable_cache_to_ram = 1'b0;
   logic          write_cache_to_ram = 1'b0;
   logic [31:0]   addr_cache_to_ram = '0;
   logic [127:0]  line_cache_to_ram = '0;
   logic          response_ram_to_cache;
   logic [127:0]  line_ram_to_cache;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ready = 1'b0;
`ifdef CACHE_RAM_TIMEOUT_EN
   logic          bus_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

   cache_ram_bridge #(
      .ADDR_W     (32),
      .WORD_W     (32),
      .LINE_WORDS (4),
      .TIMEOUT    (8)
   ) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .enable_cache_to_ram   (enable_cache_to_ram),
      .write_cache_to_ram    (write_cache_to_ram),
      .addr_cache_to_ram     (addr_cache_to_ram),
      .line_cache_to_ram     (line_cache_to_ram),
      .response_ram_to_cache (response_ram_to_cache),
      .line_ram_to_cache     (line_ram_to_cache),
      .mem_req               (mem_req),
      .mem_we                (mem_we),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .mem_rdata             (mem_rdata),
`ifdef CACHE_RAM_TIMEOUT_EN
      .mem_ready             (mem_ready),
      .bus_err               (bus_err)
`else
      .mem_ready             (mem_ready)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single read request with mem_ready tied high. The check runs through cycle LINE_WORDS+2.
   task automatic run_read(input logic [31:0] addr, input logic [31:0] base,
                           input logic [127:0] exp_line, input string tag);
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b0;
      addr_cache_to_ram   = addr;
      mem_ready           = 1'b1;
      tick();
      enable_cache_to_ram = 1'b0;
      addr_cache_to_ram   = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_req"}, 128'(mem_req), 128'(1'b1));
         check({tag, "_we"}, 128'(mem_we), 128'(1'b0));
         check({tag, "_addr"}, 128'(mem_addr), 128'(base + 32'(4 * i)));
         check({tag, "_noresp"}, 128'(response_ram_to_cache), 128'(1'b0));
         tick();
      end
      check({tag, "_resp"}, 128'(response_ram_to_cache), 128'(1'b1));
      check({tag, "_resp_req"}, 128'(mem_req), 128'(1'b0));
      check({tag, "_line"}, line_ram_to_cache, exp_line);
      tick();
      check({tag, "_idle_resp"}, 128'(response_ram_to_cache), 128'(1'b0));
      check({tag, "_idle_req"}, 128'(mem_req), 128'(1'b0));
   endtask

   localparam logic [127:0] Line1 = {32'hA5A5_123C, 32'hA5A5_1238, 32'hA5A5_1234, 32'hA5A5_1230};
   localparam logic [127:0] Line3 = {32'hA5A5_301C, 32'hA5A5_3018, 32'hA5A5_3014, 32'hA5A5_3010};
   localparam logic [127:0] Line5 = {32'hA5A5_500C, 32'hA5A5_5008, 32'hA5A5_5004, 32'hA5A5_5000};
   localparam logic [127:0] WLine = {32'hDDDD_4444, 32'hCCCC_3333, 32'hBBBB_2222, 32'hAAAA_1111};

   initial begin
      logic [31:0] wwords [4];
      int beats, resps, wbeats;
      wwords[0] = 32'hAAAA_1111;
      wwords[1] = 32'hBBBB_2222;
      wwords[2] = 32'hCCCC_3333;
      wwords[3] = 32'hDDDD_4444;

      // Reset state
      #12;
      check("rst_req", 128'(mem_req), 128'(1'b0));
      check("rst_resp", 128'(response_ram_to_cache), 128'(1'b0));
      check("rst_line", line_ram_to_cache, 128'h0);
      check("rst_addr", 128'(mem_addr), 128'h0);
      rst = 1'b1;
      tick();

      // 1: refill read with ready high
      run_read(32'h0000_1234, 32'h0000_1230, Line1, "rd1");

      // 2: write-back with 3 stall cycles per beat
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b1;
      addr_cache_to_ram   = 32'h0000_2004;
      line_cache_to_ram   = WLine;
      mem_ready           = 1'b0;
      tick();
      enable_cache_to_ram = 1'b0;
      line_cache_to_ram   = '0;
      for (int b = 0; b < 4; b++) begin
         for (int s = 0; s < 4; s++) begin
            check("wr_req", 128'(mem_req), 128'(1'b1));
            check("wr_we", 128'(mem_we), 128'(1'b1));
            check("wr_addr", 128'(mem_addr), 128'(32'h0000_2000 + 32'(4 * b)));
            check("wr_wdata", 128'(mem_wdata), 128'(wwords[b]));
            check("wr_noresp", 128'(response_ram_to_cache), 128'(1'b0));
            mem_ready = (s == 3);
            tick();
         end
      end
      mem_ready = 1'b0;
      check("wr_resp17", 128'(response_ram_to_cache), 128'(1'b1));
      check("wr_line_kept", line_ram_to_cache, Line1);
      tick();
      check("wr_idle", 128'(mem_req | response_ram_to_cache), 128'(1'b0));

      // 3: enable held high across the response; the second transfer is a refill
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b1;
      addr_cache_to_ram   = 32'h0000_3018;
      line_cache_to_ram   = WLine;
      mem_ready           = 1'b1;
      beats = 0; resps = 0; wbeats = 0;
      tick();
      for (int c = 1; c <= 14; c++) begin
         if (c == 5) write_cache_to_ram = 1'b0;
         if (c == 11) enable_cache_to_ram = 1'b0;
         if (mem_req && mem_ready) beats++;
         if (mem_req && mem_we) wbeats++;
         if (response_ram_to_cache) resps++;
         if (c == 6) check("b2b_gap_idle", 128'(mem_req), 128'(1'b0));
         if (c == 7) check("b2b_refill_we", 128'(mem_we), 128'(1'b0));
         if (c == 11) check("b2b_resp2", 128'(response_ram_to_cache), 128'(1'b1));
         tick();
      end
      check("b2b_beats", 128'(beats), 128'(8));
      check("b2b_wbeats", 128'(wbeats), 128'(4));
      check("b2b_resps", 128'(resps), 128'(2));
      check("b2b_line", line_ram_to_cache, Line3);

      // 4: reset during beat 2 of a read
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b0;
      addr_cache_to_ram   = 32'h0000_4000;
      tick();
      enable_cache_to_ram = 1'b0;
      tick();
      tick();
      check("rstmid_beat2", 128'(mem_addr), 128'(32'h0000_4008));
      #2 rst = 1'b0;
      #1;
      check("rstmid_req", 128'(mem_req), 128'(1'b0));
      check("rstmid_line", line_ram_to_cache, 128'h0);
      tick();
      rst   = 1'b1;
      resps = 0;
      for (int c = 0; c < 6; c++) begin
         if (response_ram_to_cache || mem_req) resps++;
         tick();
      end
      check("rstmid_quiet", 128'(resps), 128'(0));
      run_read(32'h0000_1234, 32'h0000_1230, Line1, "rd4");

      // 5: enable dropped in cycle 2 of a read
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b0;
      addr_cache_to_ram   = 32'h0000_5008;
      beats = 0; resps = 0;
      tick();
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) enable_cache_to_ram = 1'b0;
         if (mem_req && mem_ready) beats++;
         if (response_ram_to_cache) resps++;
         if (c >= 6) check("drop_idle", 128'(mem_req), 128'(1'b0));
         tick();
      end
      check("drop_beats", 128'(beats), 128'(4));
      check("drop_resps", 128'(resps), 128'(1));
      check("drop_line", line_ram_to_cache, Line5);

      // 6: mem_ready held low
      enable_cache_to_ram = 1'b1;
      write_cache_to_ram  = 1'b0;
      addr_cache_to_ram   = 32'h0000_6000;
      mem_ready           = 1'b0;
      tick();
      enable_cache_to_ram = 1'b0;
`ifdef CACHE_RAM_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         check("to_stall_req", 128'(mem_req), 128'(1'b1));
         check("to_stall_err", 128'(bus_err), 128'(1'b0));
         tick();
      end
      check("to_resp", 128'(response_ram_to_cache), 128'(1'b1));
      check("to_buserr", 128'(bus_err), 128'(1'b1));
      check("to_req_low", 128'(mem_req), 128'(1'b0));
      tick();
      check("to_idle", 128'(mem_req | response_ram_to_cache | bus_err), 128'(1'b0));
`else
      resps = 0;
      for (int c = 0; c < 100; c++) begin
         if (response_ram_to_cache) resps++;
         tick();
      end
      check("stall_req_held", 128'(mem_req), 128'(1'b1));
      check("stall_noresp", 128'(resps), 128'(0));
      check("stall_addr", 128'(mem_addr), 128'(32'h0000_6000));
      rst = 1'b0;
      tick();
      rst = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
